// File: rtl/poly_byte_loader_if.sv
// Byte-stream input and coefficient-RAM write bus of the polynomial loader.
// The slave modport is the loader; the master modport is its environment.
interface poly_byte_loader_if #(
  parameter int WIDTH  = 12,
  parameter int ADDR_W = 8
);
  logic [7:0]         in_byte;
  logic               in_valid;
  logic               in_ready;
  logic [8*WIDTH-1:0] w_data;
  logic [ADDR_W-1:0]  w_data_addr;
  logic               w_data_en;

  modport master (
    output in_byte, in_valid,
    input  in_ready, w_data, w_data_addr, w_data_en
  );

  modport slave (
    input  in_byte, in_valid,
    output in_ready, w_data, w_data_addr, w_data_en
  );
endinterface

// File: rtl/poly_byte_loader.sv
// Unpacks a 384-byte ByteDecode12 polynomial into 256 coefficients and bursts
// them as 32 lane-interleaved 96-bit words into the NTT coefficient RAM.
module poly_byte_loader #(
  parameter int WIDTH  = 12,
  parameter int Q      = 3329,
  parameter int ADDR_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [ADDR_W-1:0]  w_data_addr_offset,
  poly_byte_loader_if.slave  bus,
  output logic               busy,
  output logic               done,
  output logic               coef_err
);

  localparam int WORD_W = 8 * WIDTH;
  localparam logic [WIDTH-1:0] Q_W = WIDTH'(Q);

  typedef enum logic [1:0] {IDLE, COLLECT, WRITE, DONE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   offset_q, offset_d;
  logic [8:0]          byte_cnt_q, byte_cnt_d;
  logic [1:0]          phase_q, phase_d;
  logic [6:0]          group_q, group_d;
  logic [5:0]          word_cnt_q, word_cnt_d;
  logic [7:0]          b0_q, b0_d;
  logic [3:0]          b1_hi_q, b1_hi_d;
  logic                in_ready_q, in_ready_d;
  logic [WORD_W-1:0]   w_data_q, w_data_d;
  logic [ADDR_W-1:0]   w_addr_q, w_addr_d;
  logic                w_en_q, w_en_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                coef_err_q, coef_err_d;

  logic [WORD_W-1:0]   coef_mem [32];
  logic                coef_we;
  logic [7:0]          coef_n;
  logic [WIDTH-1:0]    coef_val;
  logic [4:0]          coef_word;
  logic [2:0]          coef_lane;

  function automatic logic [4:0] bitrev5(input logic [4:0] v);
    logic [4:0] r;
    for (int i = 0; i < 5; i++) r[i] = v[4-i];
    return r;
  endfunction

  always_comb begin
    state_d    = state_q;
    offset_d   = offset_q;
    byte_cnt_d = byte_cnt_q;
    phase_d    = phase_q;
    group_d    = group_q;
    word_cnt_d = word_cnt_q;
    b0_d       = b0_q;
    b1_hi_d    = b1_hi_q;
    in_ready_d = in_ready_q;
    w_data_d   = w_data_q;
    w_addr_d   = w_addr_q;
    w_en_d     = w_en_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    coef_err_d = coef_err_q;
    coef_we    = 1'b0;
    coef_n     = '0;
    coef_val   = '0;

    case (state_q)
      IDLE: begin
        if (start) begin
          offset_d   = w_data_addr_offset;
          coef_err_d = 1'b0;
          byte_cnt_d = '0;
          phase_d    = '0;
          group_d    = '0;
          word_cnt_d = '0;
          in_ready_d = 1'b1;
          busy_d     = 1'b1;
          state_d    = COLLECT;
        end
      end
      COLLECT: begin
        if (bus.in_valid && in_ready_q) begin
          byte_cnt_d = byte_cnt_q + 9'd1;
          case (phase_q)
            2'd0: begin
              b0_d    = bus.in_byte;
              phase_d = 2'd1;
            end
            2'd1: begin
              b1_hi_d  = bus.in_byte[7:4];
              coef_val = {bus.in_byte[3:0], b0_q};
              coef_n   = {group_q, 1'b0};
              coef_we  = 1'b1;
              phase_d  = 2'd2;
            end
            default: begin
              coef_val = {bus.in_byte, b1_hi_q};
              coef_n   = {group_q, 1'b1};
              coef_we  = 1'b1;
              phase_d  = 2'd0;
              group_d  = group_q + 7'd1;
            end
          endcase
          if (coef_we && coef_val >= Q_W) coef_err_d = 1'b1;
          // The last coefficient lands in word 31, so word 0 is already final here.
          if (byte_cnt_q == 9'd383) begin
            in_ready_d = 1'b0;
            w_en_d     = 1'b1;
            w_data_d   = coef_mem[0];
            w_addr_d   = offset_q;
            word_cnt_d = 6'd1;
            state_d    = WRITE;
          end
        end
      end
      WRITE: begin
        if (word_cnt_q == 6'd32) begin
          w_en_d  = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
          state_d = DONE;
        end else begin
          w_data_d   = coef_mem[word_cnt_q[4:0]];
          w_addr_d   = offset_q + ADDR_W'(word_cnt_q);
          word_cnt_d = word_cnt_q + 6'd1;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Coefficient n lives in word bitrev5(n[5:1]), lane {n[6], n[7], n[0]}.
  assign coef_word = bitrev5(coef_n[5:1]);
  assign coef_lane = {coef_n[6], coef_n[7], coef_n[0]};

  always_ff @(posedge clk) begin
    if (coef_we) coef_mem[coef_word][int'(coef_lane)*WIDTH +: WIDTH] <= coef_val;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      offset_q   <= '0;
      byte_cnt_q <= '0;
      phase_q    <= '0;
      group_q    <= '0;
      word_cnt_q <= '0;
      b0_q       <= '0;
      b1_hi_q    <= '0;
      in_ready_q <= 1'b0;
      w_data_q   <= '0;
      w_addr_q   <= '0;
      w_en_q     <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      coef_err_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      offset_q   <= offset_d;
      byte_cnt_q <= byte_cnt_d;
      phase_q    <= phase_d;
      group_q    <= group_d;
      word_cnt_q <= word_cnt_d;
      b0_q       <= b0_d;
      b1_hi_q    <= b1_hi_d;
      in_ready_q <= in_ready_d;
      w_data_q   <= w_data_d;
      w_addr_q   <= w_addr_d;
      w_en_q     <= w_en_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      coef_err_q <= coef_err_d;
    end
  end

  assign bus.in_ready    = in_ready_q;
  assign bus.w_data      = w_data_q;
  assign bus.w_data_addr = w_addr_q;
  assign bus.w_data_en   = w_en_q;
  assign busy            = busy_q;
  assign done            = done_q;
  assign coef_err        = coef_err_q;

endmodule
